// File: rtl/ra_shadow_checker_if.sv
// Snoop/status bundle between the branch unit and ra_shadow_checker.
// The stats counters only exist when RA_SHADOW_STATS_EN is defined.
interface ra_shadow_checker_if #(
  parameter int VLEN  = 32,
  parameter int DEPTH = 8
);
  logic                     en_check_i;
  logic                     call_valid_i;
  logic [VLEN-1:0]          call_link_i;
  logic                     ret_valid_i;
  logic [VLEN-1:0]          ret_target_i;
  logic                     clear_i;
  logic                     crash_o;
  logic                     mismatch_o;
  logic                     underflow_o;
  logic                     overflow_o;
  logic [$clog2(DEPTH):0]   depth_o;
`ifdef RA_SHADOW_STATS_EN
  logic [31:0]              calls_cnt_o;
  logic [31:0]              rets_cnt_o;
  logic [31:0]              mism_cnt_o;
`endif

  modport master (
    output en_check_i, call_valid_i, call_link_i, ret_valid_i, ret_target_i, clear_i,
`ifdef RA_SHADOW_STATS_EN
    input  calls_cnt_o, rets_cnt_o, mism_cnt_o,
`endif
    input  crash_o, mismatch_o, underflow_o, overflow_o, depth_o
  );

  modport slave (
    input  en_check_i, call_valid_i, call_link_i, ret_valid_i, ret_target_i, clear_i,
`ifdef RA_SHADOW_STATS_EN
    output calls_cnt_o, rets_cnt_o, mism_cnt_o,
`endif
    output crash_o, mismatch_o, underflow_o, overflow_o, depth_o
  );
endinterface

// File: rtl/ra_shadow_checker.sv
// Hardware shadow stack checking encoded return addresses against resolved returns.
// Optional saturating event counters are enabled by defining RA_SHADOW_STATS_EN.
module ra_shadow_checker #(
  parameter int              VLEN  = 32,
  parameter int              DEPTH = 8,
  parameter logic [VLEN-2:0] KEY   = 31'h73fa06c2
) (
  input logic               clk_i,
  input logic               rst_ni,
  ra_shadow_checker_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_CRASHED = 1'b1
  } state_t;

  function automatic logic [VLEN-1:0] dec(input logic [VLEN-1:0] v);
    return {1'b0, v[VLEN-2:0] ^ KEY};
  endfunction

  state_t            state_reg, state_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [DW-1:0]     depth_reg, depth_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;
  logic              pend_reg, pend_next;
  logic              malformed_reg, malformed_next;
  logic [VLEN-1:0]   target_reg, target_next;
  logic [VLEN-1:0]   stored_reg;
  logic [VLEN-1:0]   mem [DEPTH];

  logic              check_fail;
  logic              promote;
  logic              accept;
  logic              do_pop;
  logic              do_push;
  logic              do_underflow;
  logic              full;
  logic [PW-1:0]     top_idx;
  logic [PW-1:0]     wr_idx;

  // A malformed call is a failed check just like a bad return, so it can crash too.
  assign check_fail   = (pend_reg && (stored_reg != target_reg)) || malformed_reg;
  assign promote      = (state_reg == ST_RUN) && check_fail && bus.en_check_i;
  // Nothing is accepted while crashing, crashed, or being cleared.
  assign accept       = (state_reg == ST_RUN) && !promote && !bus.clear_i;
  assign do_pop       = accept && bus.ret_valid_i && (depth_reg != '0);
  assign do_underflow = accept && bus.ret_valid_i && (depth_reg == '0);
  assign do_push      = accept && bus.call_valid_i;
  assign full         = (depth_reg == DW'(DEPTH));
  assign top_idx      = ptr_reg - PW'(1);
  // On a simultaneous pop+push the new call lands in the slot just vacated.
  assign wr_idx       = do_pop ? top_idx : ptr_reg;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    depth_next     = depth_reg;
    overflow_next  = overflow_reg;
    underflow_next = do_underflow;
    pend_next      = do_pop;
    malformed_next = do_push && !bus.call_link_i[VLEN-1];
    target_next    = do_pop ? dec(bus.ret_target_i) : target_reg;

    case (state_reg)
      ST_RUN:     if (!bus.clear_i && promote) state_next = ST_CRASHED;
      ST_CRASHED: if (bus.clear_i)             state_next = ST_RUN;
      default:                                 state_next = ST_RUN;
    endcase

    if (bus.clear_i) begin
      ptr_next      = '0;
      depth_next    = '0;
      overflow_next = 1'b0;
    end else if (do_pop && !do_push) begin
      ptr_next   = ptr_reg - PW'(1);
      depth_next = depth_reg - DW'(1);
    end else if (do_push && !do_pop) begin
      ptr_next = ptr_reg + PW'(1);
      if (full) overflow_next = 1'b1;
      else      depth_next    = depth_reg + DW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_RUN;
      ptr_reg       <= '0;
      depth_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      pend_reg      <= 1'b0;
      malformed_reg <= 1'b0;
      target_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      depth_reg     <= depth_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      pend_reg      <= pend_next;
      malformed_reg <= malformed_next;
      target_reg    <= target_next;
    end
  end

  // Storage has no reset so it maps onto RAM; the read is read-before-write.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_idx] <= dec(bus.call_link_i);
    if (do_pop)  stored_reg  <= mem[top_idx];
  end

  assign bus.crash_o     = (state_reg == ST_CRASHED) || promote;
  assign bus.mismatch_o  = check_fail;
  assign bus.underflow_o = underflow_reg;
  assign bus.overflow_o  = overflow_reg;
  assign bus.depth_o     = depth_reg;

`ifdef RA_SHADOW_STATS_EN
  logic [31:0] calls_cnt_reg, rets_cnt_reg, mism_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      calls_cnt_reg <= '0;
      rets_cnt_reg  <= '0;
      mism_cnt_reg  <= '0;
    end else begin
      if (do_push    && (calls_cnt_reg != '1)) calls_cnt_reg <= calls_cnt_reg + 32'd1;
      if (do_pop     && (rets_cnt_reg  != '1)) rets_cnt_reg  <= rets_cnt_reg  + 32'd1;
      if (check_fail && (mism_cnt_reg  != '1)) mism_cnt_reg  <= mism_cnt_reg  + 32'd1;
    end
  end

  assign bus.calls_cnt_o = calls_cnt_reg;
  assign bus.rets_cnt_o  = rets_cnt_reg;
  assign bus.mism_cnt_o  = mism_cnt_reg;
`endif

endmodule
